// File: rtl/dcache_mem_pkg.sv
// Constants and FSM encoding shared by the data cache and its memory-side controller.
package dcache_mem_pkg;

  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned LINE_BITS   = LINE_WORDS * WORD_BITS;
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned LAT_W       = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_WAIT     = 3'd1;
  localparam state_t S_RD_BURST = 3'd2;
  localparam state_t S_RD_LAST  = 3'd3;
  localparam state_t S_WR       = 3'd4;
  localparam state_t S_RESP     = 3'd5;

endpackage

// File: rtl/dcache_mem_ctrl_if.sv
// Cache request/response and backing-RAM bus seen by dcache_mem_ctrl.
interface dcache_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 12
) ();
  import dcache_mem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [LINE_BITS-1:0] resp_line;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_line, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Cache plus backing RAM side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_line, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_latency_timer.sv
// Loadable down-counter; done_o flags the last wait cycle (count of one or zero).
module mem_latency_timer
  import dcache_mem_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller for the data cache: delayed 4-word line fills and
// write-through word stores against a synchronous-read word RAM.
module dcache_mem_ctrl
  import dcache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  dcache_mem_ctrl_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT = LAT_W'(MEM_LATENCY);

  state_t               state_q, state_d;
  logic                 we_q;
  logic [ADDR_W-1:0]    widx_q;
  logic [31:0]          wdata_q;
  logic [1:0]           k_q, k_d;
  logic [1:0]           km1;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [ADDR_W-1:0]    maddr_q, maddr_d;
  logic [31:0]          mwdata_q, mwdata_d;

  logic                 accept, wait_done, start;
  logic                 go_we;
  logic [ADDR_W-1:0]    go_idx, widx_in;
  logic [31:0]          go_wd;
  logic                 unused_addr_bits;

  assign widx_in          = bus.req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
  assign accept           = bus.req_valid & bus.req_ready;
  assign km1              = k_q - 2'd1;

  // With zero latency the access starts straight from IDLE using the live request.
  assign go_we  = (state_q == S_IDLE) ? bus.req_we    : we_q;
  assign go_idx = (state_q == S_IDLE) ? widx_in       : widx_q;
  assign go_wd  = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;

  mem_latency_timer #(.W(LAT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (LAT),
    .done_o     (wait_done)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    line_d   = line_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LAT == '0) start = 1'b1;
          else           state_d = S_WAIT;
        end
      end
      S_WAIT:     if (wait_done) start = 1'b1;
      S_RD_BURST: begin
        // Read data lags the strobe by one cycle, so word k-1 lands while word k is requested.
        if (k_q != 2'd0)
          line_d[{km1, 5'b0} +: WORD_BITS] = bus.mem_rdata;
        if (k_q == 2'd3) begin
          state_d = S_RD_LAST;
        end else begin
          k_d     = k_q + 2'd1;
          maddr_d = {maddr_q[ADDR_W-1:2], k_q + 2'd1};
        end
      end
      S_RD_LAST: begin
        line_d[3*WORD_BITS +: WORD_BITS] = bus.mem_rdata;
        state_d = S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      k_d = '0;
      if (go_we) begin
        state_d  = S_WR;
        maddr_d  = go_idx;
        mwdata_d = go_wd;
      end else begin
        state_d  = S_RD_BURST;
        maddr_d  = {go_idx[ADDR_W-1:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      k_q      <= '0;
      line_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      line_q   <= line_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      if (accept) begin
        we_q    <= bus.req_we;
        widx_q  <= widx_in;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) & ~reset;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_line  = line_q;
  assign bus.mem_en     = (state_q == S_RD_BURST) | (state_q == S_WR);
  assign bus.mem_we     = (state_q == S_WR);
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;

endmodule
